// File: rtl/max7219_pkg.sv
// Shared register map, sequencer state encoding and fixed word sequences for the MAX7219 driver.
// Pure declarations: no state and no handshake of its own.
package max7219_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_INIT  = 2'd1,
        ST_FRAME = 2'd2
    } state_t;

    localparam logic [7:0] REG_DECODE    = 8'h09;
    localparam logic [7:0] REG_INTENSITY = 8'h0A;
    localparam logic [7:0] REG_SCANLIM   = 8'h0B;
    localparam logic [7:0] REG_SHUTDOWN  = 8'h0C;
    localparam logic [7:0] REG_TEST      = 8'h0F;

    localparam int INIT_WORDS  = 5;
    localparam int FRAME_WORDS = 9;

    // Init order: leave test mode, wake up, scan all 8 digits, brightness, raw segment mode.
    function automatic logic [15:0] init_word(input logic [3:0] idx, input logic [3:0] inten);
        logic [15:0] w;
        case (idx)
            4'd0:    w = {REG_TEST, 8'h00};
            4'd1:    w = {REG_SHUTDOWN, 8'h01};
            4'd2:    w = {REG_SCANLIM, 8'h07};
            4'd3:    w = {REG_INTENSITY, 4'h0, inten};
            default: w = {REG_DECODE, 8'h00};
        endcase
        return w;
    endfunction

endpackage

// File: rtl/max7219_hex_seg.sv
// Hex nibble to no-decode segment pattern, bit6..0 = A..G.
// Combinational, zero latency, no handshake.
module max7219_hex_seg (
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);
    always_comb begin
        case (i_hex)
            4'h0:    o_seg = 7'h7E;
            4'h1:    o_seg = 7'h30;
            4'h2:    o_seg = 7'h6D;
            4'h3:    o_seg = 7'h79;
            4'h4:    o_seg = 7'h33;
            4'h5:    o_seg = 7'h5B;
            4'h6:    o_seg = 7'h5F;
            4'h7:    o_seg = 7'h70;
            4'h8:    o_seg = 7'h7F;
            4'h9:    o_seg = 7'h7B;
            4'hA:    o_seg = 7'h77;
            4'hB:    o_seg = 7'h1F;
            4'hC:    o_seg = 7'h4E;
            4'hD:    o_seg = 7'h3D;
            4'hE:    o_seg = 7'h4F;
            default: o_seg = 7'h47;
        endcase
    end
endmodule

// File: rtl/max7219_frame_seq.sv
// Emits MAX7219 init and 9-word display frames as registered (addr,data) words; first word one cycle
// after the trigger, next word one cycle after each transfer; a word holds while cmd_ready is low.
module max7219_frame_seq
    import max7219_pkg::*;
#(
    parameter int REFRESH_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset_sw,
    input  logic [31:0] value,
    input  logic [7:0]  dp,
    input  logic [3:0]  intensity,
    input  logic        load,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [7:0]  cmd_addr,
    output logic [7:0]  cmd_data,
    output logic        busy,
    output logic        init_done
);
    localparam int         CNT_W      = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [3:0] INIT_LAST  = 4'(INIT_WORDS - 1);
    localparam logic [3:0] FRAME_LAST = 4'(FRAME_WORDS - 1);

    state_t           r_state;
    logic [3:0]       r_idx;
    logic [31:0]      r_sh_val;
    logic [7:0]       r_sh_dp;
    logic [3:0]       r_sh_int;
    logic [31:0]      r_wk_val;
    logic [7:0]       r_wk_dp;
    logic             r_pending;
    logic             r_init_done;
    logic [CNT_W-1:0] r_ref_cnt;

    logic [31:0] w_sh_val;
    logic [7:0]  w_sh_dp;
    logic [3:0]  w_sh_int;
    logic        w_xfer;
    logic        w_last;
    logic        w_ref_hit;
    logic        w_frame_go;
    logic        w_init_go;
    logic        w_idle_go;
    logic [3:0]  w_seg_hex;
    logic [6:0]  w_seg;

    // Shadow as it will be after this edge, so a load coinciding with frame entry is not missed.
    assign w_sh_val = load ? value : r_sh_val;
    assign w_sh_dp  = load ? dp : r_sh_dp;
    assign w_sh_int = load ? intensity : r_sh_int;

    assign w_xfer    = cmd_valid && cmd_ready;
    assign w_last    = (r_state == ST_INIT && r_idx == INIT_LAST) ||
                       (r_state == ST_FRAME && r_idx == FRAME_LAST);
    assign w_ref_hit = (REFRESH_CYCLES > 0) && ((int'(r_ref_cnt) + 1) >= REFRESH_CYCLES);

    assign w_frame_go = (r_state == ST_IDLE && load && r_init_done) ||
                        (w_xfer && w_last && (r_state == ST_INIT || r_pending || load));
    assign w_init_go  = (r_state == ST_IDLE) && !w_frame_go && (!r_init_done || w_ref_hit);
    assign w_idle_go  = w_xfer && w_last && !w_frame_go;

    // Word idx+1 shows digit idx, so the lookup runs one word ahead of the presented one.
    assign w_seg_hex = r_wk_val[{r_idx[2:0], 2'b00} +: 4];

    max7219_hex_seg u_hex_seg (
        .i_hex (w_seg_hex),
        .o_seg (w_seg)
    );

    assign busy      = (r_state != ST_IDLE);
    assign init_done = r_init_done;

    always_ff @(posedge clk) begin
        if (reset_sw) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            cmd_valid   <= 1'b0;
            cmd_addr    <= '0;
            cmd_data    <= '0;
            r_init_done <= 1'b0;
            r_pending   <= 1'b0;
            r_sh_val    <= '0;
            r_sh_dp     <= '0;
            r_sh_int    <= 4'hF;
            r_wk_val    <= '0;
            r_wk_dp     <= '0;
            r_ref_cnt   <= '0;
        end else begin
            r_sh_val <= w_sh_val;
            r_sh_dp  <= w_sh_dp;
            r_sh_int <= w_sh_int;

            if (w_frame_go) begin
                r_state   <= ST_FRAME;
                r_idx     <= '0;
                r_wk_val  <= w_sh_val;
                r_wk_dp   <= w_sh_dp;
                r_pending <= 1'b0;
                cmd_valid <= 1'b1;
                cmd_addr  <= REG_INTENSITY;
                cmd_data  <= {4'h0, w_sh_int};
            end else if (w_init_go) begin
                r_state   <= ST_INIT;
                r_idx     <= '0;
                r_pending <= r_pending || load;
                cmd_valid <= 1'b1;
                {cmd_addr, cmd_data} <= init_word(4'd0, w_sh_int);
            end else if (w_idle_go) begin
                r_state   <= ST_IDLE;
                cmd_valid <= 1'b0;
            end else begin
                if (load && r_state != ST_IDLE) begin
                    r_pending <= 1'b1;
                end
                if (w_xfer) begin
                    r_idx <= r_idx + 4'd1;
                    if (r_state == ST_INIT) begin
                        {cmd_addr, cmd_data} <= init_word(r_idx + 4'd1, w_sh_int);
                    end else begin
                        cmd_addr <= {4'h0, r_idx + 4'd1};
                        cmd_data <= {r_wk_dp[r_idx[2:0]], w_seg};
                    end
                end
            end

            if (w_xfer && w_last && r_state == ST_INIT) begin
                r_init_done <= 1'b1;
            end

            if (r_state == ST_IDLE && !w_frame_go && !w_init_go) begin
                r_ref_cnt <= r_ref_cnt + CNT_W'(1);
            end else begin
                r_ref_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_max7219_frame_seq.sv
// Randomised bench for max7219_frame_seq: stimulus pushes expected command words into a queue,
// a monitor pops and compares on every accepted word.
module tb_max7219_frame_seq;

    typedef struct packed {
        logic       last_init;
        logic [7:0] addr;
        logic [7:0] data;
    } word_t;

    logic        clk       = 1'b0;
    logic        reset_sw  = 1'b1;
    logic [31:0] value     = '0;
    logic [7:0]  dp        = '0;
    logic [3:0]  intensity = '0;
    logic        load      = 1'b0;
    logic        cmd_ready = 1'b0;
    logic        cmd_valid;
    logic [7:0]  cmd_addr;
    logic [7:0]  cmd_data;
    logic        busy;
    logic        init_done;

    max7219_frame_seq #(.REFRESH_CYCLES(100)) dut (
        .clk       (clk),
        .reset_sw  (reset_sw),
        .value     (value),
        .dp        (dp),
        .intensity (intensity),
        .load      (load),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .busy      (busy),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    word_t exp_q[$];
    int    n_vec    = 0;
    int    n_err    = 0;
    bit    exp_done = 1'b0;
    int    rdy_mode = 0;
    int    xfer_cnt = 0;
    int    xfer_lim = 0;

    // Model shadow: the values a refresh or post-reset frame must show.
    logic [31:0] m_val = '0;
    logic [7:0]  m_dp  = '0;
    logic [3:0]  m_int = 4'hF;

    logic [6:0] SEG [0:15] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_init(input int cnt, input logic [3:0] inten);
        word_t w [5];
        w[0] = {1'b0, 8'h0F, 8'h00};
        w[1] = {1'b0, 8'h0C, 8'h01};
        w[2] = {1'b0, 8'h0B, 8'h07};
        w[3] = {1'b0, 8'h0A, 4'h0, inten};
        w[4] = {1'b1, 8'h09, 8'h00};
        for (int k = 0; k < cnt; k++) exp_q.push_back(w[k]);
    endtask

    task automatic push_frame(input logic [31:0] v, input logic [7:0] d, input logic [3:0] inten);
        exp_q.push_back({1'b0, 8'h0A, 4'h0, inten});
        for (int n = 0; n < 8; n++) exp_q.push_back({1'b0, 8'(n + 1), d[n], SEG[v[4*n +: 4]]});
    endtask

    task automatic do_load(input logic [31:0] v, input logic [7:0] d, input logic [3:0] inten);
        value = v; dp = d; intensity = inten; load = 1'b1;
        m_val = v; m_dp = d; m_int = inten;
        step();
        load = 1'b0;
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            step();
            t++;
        end
        if (exp_q.size() != 0) begin
            n_vec++; n_err++;
            $display("FAIL %s_timeout: %0d words outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (3) step();
        @(negedge clk);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_valid"}, 32'(cmd_valid), 32'd0);
    endtask

    // Ready driver: 0 always ready, 1 one cycle in three, 2 random, 3 ready until xfer_lim words.
    initial begin
        int ph = 0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: cmd_ready = 1'b1;
                1: begin cmd_ready = (ph == 0); ph = (ph + 1) % 3; end
                2: cmd_ready = 1'($urandom_range(0, 1));
                default: cmd_ready = (xfer_cnt < xfer_lim);
            endcase
        end
    end

    // Monitor: compare each accepted word, and that a stalled word does not change.
    initial begin
        word_t w;
        word_t held;
        bit    stall    = 1'b0;
        bit    prev_rst = 1'b1;
        held = '0;
        forever begin
            @(negedge clk);
            if (stall && !prev_rst && !reset_sw)
                check("hold", {15'd0, cmd_valid, cmd_addr, cmd_data}, {15'd0, 1'b1, held.addr, held.data});
            stall = cmd_valid && !cmd_ready;
            held  = {1'b0, cmd_addr, cmd_data};
            if (cmd_valid && cmd_ready) begin
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL extra_word: got %h/%h, expected no word", cmd_addr, cmd_data);
                end else begin
                    w = exp_q.pop_front();
                    check("word", {16'd0, cmd_addr, cmd_data}, {16'd0, w.addr, w.data});
                    check("init_done", 32'(init_done), 32'(exp_done));
                    if (w.last_init) exp_done = 1'b1;
                end
            end
            prev_rst = reset_sw;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v, vl;
        logic [7:0]  d, dl;
        logic [3:0]  it, itl;
        int          k;

        // Reset values and boot sequence.
        rdy_mode = 0;
        repeat (3) step();
        @(negedge clk);
        check("rst_valid", 32'(cmd_valid), 32'd0);
        check("rst_addr", 32'(cmd_addr), 32'd0);
        check("rst_data", 32'(cmd_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        push_init(5, 4'hF);
        push_frame(32'h0, 8'h0, 4'hF);
        step();
        reset_sw = 1'b0;
        @(negedge clk);
        check("pre_init_valid", 32'(cmd_valid), 32'd0);
        @(negedge clk);
        check("first_valid", 32'(cmd_valid), 32'd1);
        check("first_addr", 32'(cmd_addr), 32'h0F);
        drain("boot");
        check("init_done_hi", 32'(init_done), 32'd1);

        // Directed digit pattern.
        do_load(32'h89ABCDEF, 8'h01, 4'h3);
        push_frame(32'h89ABCDEF, 8'h01, 4'h3);
        drain("directed");

        // Slow ready.
        rdy_mode = 1;
        v = $urandom; d = 8'($urandom); it = 4'($urandom);
        do_load(v, d, it);
        push_frame(v, d, it);
        drain("slow_ready");

        // Three loads during one frame coalesce into one further frame.
        v = $urandom; it = 4'($urandom);
        do_load(v, 8'h00, it);
        push_frame(v, 8'h00, it);
        repeat (2) step();
        do_load(32'h11111111, 8'h00, 4'h5);
        do_load(32'h22222222, 8'h00, 4'h6);
        do_load(32'h33333333, 8'h00, 4'h7);
        push_frame(32'h33333333, 8'h00, 4'h7);
        drain("coalesce");

        // Load in the same cycle as the last frame word transfer.
        rdy_mode = 0;
        v = $urandom; d = 8'($urandom); it = 4'($urandom);
        do_load(v, d, it);
        push_frame(v, d, it);
        repeat (8) step();
        vl = $urandom; dl = 8'($urandom); itl = 4'($urandom);
        do_load(vl, dl, itl);
        push_frame(vl, dl, itl);
        drain("last_cycle_load");

        // Random frames with random ready and optional coalesced loads.
        for (int it_n = 0; it_n < 12; it_n++) begin
            rdy_mode = $urandom_range(0, 2);
            v = $urandom; d = 8'($urandom); it = 4'($urandom);
            do_load(v, d, it);
            push_frame(v, d, it);
            k = $urandom_range(0, 3);
            for (int j = 0; j < k; j++) begin
                step();
                vl = $urandom; dl = 8'($urandom); itl = 4'($urandom);
                do_load(vl, dl, itl);
            end
            if (k > 0) push_frame(vl, dl, itl);
            drain("random");
        end

        // Reset while INIT word 3 is stalled.
        rdy_mode = 3;
        xfer_lim = xfer_cnt + 3;
        step();
        reset_sw = 1'b1;
        step();
        reset_sw = 1'b0;
        m_val = '0; m_dp = '0; m_int = 4'hF;
        exp_done = 1'b0;
        push_init(3, 4'hF);
        k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            step();
            k++;
        end
        check("init3_queue", 32'(exp_q.size()), 32'd0);
        repeat (2) step();
        @(negedge clk);
        check("init3_valid", 32'(cmd_valid), 32'd1);
        check("init3_addr", 32'(cmd_addr), 32'h0A);
        step();
        reset_sw = 1'b1;
        step();
        rdy_mode = 0;
        reset_sw = 1'b0;
        @(negedge clk);
        check("midrst_valid", 32'(cmd_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_init_done", 32'(init_done), 32'd0);
        exp_q.delete();
        push_init(5, 4'hF);
        push_frame(32'h0, 8'h0, 4'hF);
        drain("restart");

        // Idle refresh re-emits INIT and FRAME from the last loaded values.
        v = $urandom; d = 8'($urandom); it = 4'($urandom);
        do_load(v, d, it);
        push_frame(v, d, it);
        drain("pre_refresh");
        repeat (70) step();
        @(negedge clk);
        check("no_early_refresh", 32'(cmd_valid), 32'd0);
        push_init(5, m_int);
        push_frame(m_val, m_dp, m_int);
        drain("refresh");
        check("refresh_init_done", 32'(init_done), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
